// File: rtl/irq_edge_controller.sv
// ============================================================================
// Module      : irq_edge_controller
// Description : Edge-triggered interrupt controller with fixed-priority arbiter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_edge_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    output logic                irq_valid,
    output logic [ID_W-1:0]     irq_id,
    input  logic                irq_ack
);

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_RISE_EN = 2'd1;
    localparam logic [1:0] ADDR_FALL_EN = 2'd2;
    localparam logic [1:0] ADDR_PENDING = 2'd3;

    logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_IRQ-1:0] enable_q, rise_en_q, fall_en_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               irq_valid_q, irq_valid_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;

    logic [NUM_IRQ-1:0] fire;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [NUM_IRQ-1:0] candidates;
    logic               ack_accept;
    logic [NUM_IRQ-1:0] wdata_irq;
    logic               unused_wdata;

    assign wdata_irq    = cfg_wdata[NUM_IRQ-1:0];
    assign unused_wdata = ^cfg_wdata;

    assign fire = (sync2_q & ~prev_q & rise_en_q) | (~sync2_q & prev_q & fall_en_q);

    // An ack is only meaningful while something is actually presented.
    assign ack_accept = irq_ack & irq_valid_q;
    assign w1c_mask   = (cfg_we && (cfg_addr == ADDR_PENDING)) ? wdata_irq : '0;

    always_comb begin
        ack_mask = '0;
        if (ack_accept) begin
            ack_mask[irq_id_q] = 1'b1;
        end
    end

    // Set wins over any clear landing in the same cycle.
    assign pending_d  = (pending_q & ~(w1c_mask | ack_mask)) | fire;
    assign candidates = pending_q & enable_q;

    always_comb begin
        irq_valid_d = 1'b0;
        irq_id_d    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                irq_valid_d = 1'b1;
                irq_id_d    = ID_W'(i);
            end
        end
        // Forcing valid low on acceptance guarantees one idle cycle, so a held ack
        // cannot retire the next source too.
        if (ack_accept) begin
            irq_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            enable_q    <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pending_q   <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            sync1_q     <= irq_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pending_q   <= pending_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_ENABLE:  enable_q  <= wdata_irq;
                    ADDR_RISE_EN: rise_en_q <= wdata_irq;
                    ADDR_FALL_EN: fall_en_q <= wdata_irq;
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata[NUM_IRQ-1:0] = enable_q;
            ADDR_RISE_EN: cfg_rdata[NUM_IRQ-1:0] = rise_en_q;
            ADDR_FALL_EN: cfg_rdata[NUM_IRQ-1:0] = fall_en_q;
            default:      cfg_rdata[NUM_IRQ-1:0] = pending_q;
        endcase
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_edge_controller.sv
// ============================================================================
// Module      : tb_irq_edge_controller
// Description : Directed self-checking bench for irq_edge_controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_edge_controller;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_in;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic               irq_valid;
    logic [ID_W-1:0]    irq_id;
    logic               irq_ack;

    int checks = 0;
    int errors = 0;

    irq_edge_controller #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        cfg_addr = addr;
        #1;
        check(tag, cfg_rdata, exp);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] id);
        check({tag, "_valid"}, {31'd0, irq_valid}, {31'd0, v});
        if (v) check({tag, "_id"}, 32'(irq_id), id);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = '0; irq_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", {31'd0, irq_valid}, 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check_reg("rst_enable", 2'd0, 32'h0);
        check_reg("rst_rise", 2'd1, 32'h0);
        check_reg("rst_fall", 2'd2, 32'h0);
        check_reg("rst_pend", 2'd3, 32'h0);

        // Rising edge on line 0, latency and ack
        cfg_write(2'd1, 32'h01);
        cfg_write(2'd0, 32'h01);
        check_reg("rise_readback", 2'd1, 32'h01);
        irq_in = 8'h01;
        tick(); tick();                                   // E0, E1
        check_reg("t1_pend_e1", 2'd3, 32'h00);
        tick();                                           // E2
        check_reg("t1_pend_e2", 2'd3, 32'h01);
        check("t1_valid_e2", {31'd0, irq_valid}, 32'd0);
        tick();                                           // E3
        check_out("t1_e3", 1'b1, 32'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t1_ack_valid", {31'd0, irq_valid}, 32'd0);
        check_reg("t1_ack_pend", 2'd3, 32'h00);
        tick();
        check("t1_post_valid", {31'd0, irq_valid}, 32'd0);
        irq_in = 8'h00;                                   // fall ignored, FALL_EN=0
        tick(); tick(); tick(); tick();
        check_reg("t1_fall_ign", 2'd3, 32'h00);

        // Falling edge only on line 2
        cfg_write(2'd1, 32'h00);
        cfg_write(2'd2, 32'h04);
        cfg_write(2'd0, 32'h04);
        irq_in = 8'h04;
        for (int i = 0; i < 5; i++) tick();
        check_reg("t2_no_rise", 2'd3, 32'h00);
        check("t2_no_valid", {31'd0, irq_valid}, 32'd0);
        irq_in = 8'h00;
        tick(); tick();
        check_reg("t2_pend_e1", 2'd3, 32'h00);
        tick();
        check_reg("t2_pend_e2", 2'd3, 32'h04);
        tick();
        check_out("t2_e3", 1'b1, 32'd2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t2_ack_valid", {31'd0, irq_valid}, 32'd0);
        check_reg("t2_ack_pend", 2'd3, 32'h00);

        // Priority: lines 5 and 3 together, held ack
        cfg_write(2'd2, 32'h00);
        cfg_write(2'd1, 32'hFF);
        cfg_write(2'd0, 32'hFF);
        irq_in = 8'h28;
        tick(); tick(); tick();
        check_reg("t3_pend", 2'd3, 32'h28);
        tick();
        check_out("t3_first", 1'b1, 32'd3);
        irq_ack = 1'b1;
        tick();
        check("t3_gap_valid", {31'd0, irq_valid}, 32'd0);
        check_reg("t3_gap_pend", 2'd3, 32'h20);
        tick();
        check_out("t3_second", 1'b1, 32'd5);
        tick();
        check("t3_done_valid", {31'd0, irq_valid}, 32'd0);
        check_reg("t3_done_pend", 2'd3, 32'h00);
        tick();
        check("t3_held_ack_idle", {31'd0, irq_valid}, 32'd0);
        irq_ack = 1'b0;
        irq_in = 8'h00;
        tick(); tick(); tick(); tick();

        // Disabled line keeps pending, presents once enabled
        cfg_write(2'd0, 32'h00);
        irq_in = 8'h02;
        tick(); tick(); tick(); tick();
        check_reg("t4_pend", 2'd3, 32'h02);
        check("t4_masked_valid", {31'd0, irq_valid}, 32'd0);
        cfg_write(2'd0, 32'h02);
        check("t4_en_edge_valid", {31'd0, irq_valid}, 32'd0);
        tick();
        check_out("t4_enabled", 1'b1, 32'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check_reg("t4_ack_pend", 2'd3, 32'h00);
        irq_in = 8'h00;
        tick(); tick(); tick(); tick();

        // Set beats W1C and ack on line 4
        cfg_write(2'd0, 32'h10);
        irq_in = 8'h10;
        tick(); tick(); tick();
        check_reg("t5_pend", 2'd3, 32'h10);
        tick();
        check_out("t5_present", 1'b1, 32'd4);
        irq_in = 8'h00;
        tick(); tick(); tick(); tick();
        irq_in = 8'h10;
        tick(); tick();                                   // E0, E1: edge fires
        cfg_write(2'd3, 32'h10);                          // W1C lands on E2
        check_reg("t5_w1c_vs_set", 2'd3, 32'h10);
        check_out("t5_w1c_still", 1'b1, 32'd4);
        irq_in = 8'h00;
        tick(); tick(); tick(); tick();
        irq_in = 8'h10;
        tick(); tick();
        irq_ack = 1'b1;
        tick();                                           // ack + set on E2
        irq_ack = 1'b0;
        check("t5_ack_drop", {31'd0, irq_valid}, 32'd0);
        check_reg("t5_ack_vs_set", 2'd3, 32'h10);
        tick();
        check_out("t5_reassert", 1'b1, 32'd4);

        // Withdrawal by W1C without a coincident edge
        cfg_write(2'd3, 32'h10);
        check_reg("t5_wd_pend", 2'd3, 32'h00);
        check("t5_wd_lag", {31'd0, irq_valid}, 32'd1);
        tick();
        check("t5_wd_valid", {31'd0, irq_valid}, 32'd0);

        // Reset while presenting; held-high line raises nothing afterwards
        cfg_write(2'd0, 32'hFF);
        irq_in = 8'h40;
        tick(); tick(); tick(); tick();
        check_out("t6_pre", 1'b1, 32'd6);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", {31'd0, irq_valid}, 32'd0);
        check("t6_rst_id", 32'(irq_id), 32'd0);
        check_reg("t6_rst_enable", 2'd0, 32'h0);
        check_reg("t6_rst_rise", 2'd1, 32'h0);
        check_reg("t6_rst_fall", 2'd2, 32'h0);
        check_reg("t6_rst_pend", 2'd3, 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_reg("t6_held_pend", 2'd3, 32'h0);
        check("t6_held_valid", {31'd0, irq_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_edge_controller.md
Name: irq_edge_controller

Overview:
- Interrupt controller for NUM_IRQ asynchronous external event lines (GPIO, timer and UART flags).
- Each line passes through a 2-flop synchronizer and a per-line rising/falling edge detector whose edge mode is software-configurable.
- Detected edges are latched into pending bits. A fixed-priority arbiter presents one interrupt at a time to the CPU over a valid/ack handshake.
- Configuration goes through a small word-addressed register port driven by the peripheral bus.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..32).
- ID_W, $clog2(NUM_IRQ) (minimum 1), width of irq_id.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NUM_IRQ  raw asynchronous event lines.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  2  register select.
- cfg_wdata  input  32  write data; bits above NUM_IRQ-1 are ignored.
- cfg_rdata  output  32  combinational read data for cfg_addr; upper bits read 0.
- irq_valid  output  1  an enabled pending interrupt is presented.
- irq_id  output  ID_W  index of the presented source.
- irq_ack  input  1  CPU accepts the presented interrupt.

Behaviour:
- Register map:
  - 0 ENABLE (RW)
  - 1 RISE_EN (RW)
  - 2 FALL_EN (RW)
  - 3 PENDING: read returns pending bits; write is write-1-to-clear.
- Reset: ENABLE, RISE_EN, FALL_EN, PENDING, both sync stages and prev all clear to 0; irq_valid=0, irq_id=0.
- After reset, a line held high shows a rising edge. It is discarded because RISE_EN=0.
- Synchronizer: s1<=irq_in, s2<=s1, prev<=s2.
- Edge detection: rise[i]=s2&~prev, fall[i]=~s2&prev. Edge i fires when (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
- Pending set:
  - A fired edge sets PENDING[i] regardless of ENABLE. A disabled line keeps its pending bit and presents it once enabled.
  - Set has priority over every clear (W1C or ack) in the same cycle.
- Latency: irq_in changes before edge E0 → s1 at E0 → edge fires combinationally after E1 → PENDING set at E2 → irq_valid/irq_id at E3.
- Arbiter: candidates = PENDING & ENABLE. Lowest index wins. irq_valid and irq_id are registered at every edge from the current candidates.
- Ack handshake:
  - irq_ack is accepted only when irq_valid=1. irq_ack with irq_valid=0 is ignored.
  - On acceptance, PENDING[irq_id] clears (unless re-set that cycle) and irq_valid is forced to 0 at the same edge.
  - At the next edge irq_valid/irq_id are re-evaluated. irq_valid is therefore low for exactly one cycle between back-to-back interrupts, so a held ack cannot double-accept.
- Withdrawal:
  - Clearing ENABLE[i] or PENDING[i] (by W1C) of the presented source withdraws it: irq_valid/irq_id update at the next edge.
  - An ack arriving in the same cycle as that write is still accepted.
- Writes take effect at the clock edge; reads reflect the registered values.
- Pending edges are not counted: repeated edges on a line that is already pending merge into one.
- Reset mid-operation clears all state at the next edge. Any edges in flight are lost.

Test Plan:
- Reset, then write RISE_EN=0x01, ENABLE=0x01; raise irq_in[0] before E0 → PENDING=0x01 after E2, irq_valid=1 and irq_id=0 after E3; pulse irq_ack → irq_valid=0 next edge, PENDING=0.
- FALL_EN=0x04, ENABLE=0x04; pulse irq_in[2] high for 5 cycles → pending only after the falling edge; no pending on the rise.
- RISE_EN=0xFF, ENABLE=0xFF; raise lines 5 and 3 together → irq_id=3 first; hold ack high → irq_id=5 presented after exactly one idle cycle; then irq_valid=0 and PENDING=0.
- ENABLE=0; edge on line 1 → PENDING=0x02, irq_valid stays 0; write ENABLE=0x02 → irq_valid=1 and irq_id=1 after the following edge.
- Same-cycle W1C of bit 4 and a new rising edge on line 4 → PENDING[4] stays 1. Same-cycle ack of line 4 and a new edge on line 4 → irq_valid drops for one cycle, then re-asserts with irq_id=4.
- Assert reset while irq_valid=1 → all registers, cfg_rdata of every address, and irq_valid read 0 after that edge; a line held high through reset raises no interrupt.
